// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM and frame-class
// encodings, the row/column to hex key map, and the column strobe reset pattern.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_e;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_class_e;

   // Column 0 is strobed first after reset (active-low one-hot)
   localparam logic [3:0] COL_RESET = 4'b1110;

   // Indexed by {row, col}; entry 0 is row 0 / column 0.
   // Row 3 carries '*' as E and '#' as F, matching the display's hex glyphs.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] keyLookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column strobe generator and row sampler. Walks one active-low column per
// slot, samples the synchronized rows at the end of each slot and summarizes
// every four-slot frame as NONE / SINGLE(key) / MULTI.
module keypad_col_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   row_i,
   output logic [3:0]   col_o,
   output logic         frameDone_o,
   output frame_class_e frameClass_o,
   output logic [3:0]   frameKey_o
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

   logic [3:0]        rowMeta_q;
   logic [3:0]        rowSync_q;
   logic [SLOT_W-1:0] slotCnt_q;
   logic [3:0]        col_q;
   logic [1:0]        colIdx_q;
   logic [1:0]        pressCnt_q;
   logic [3:0]        firstKey_q;

   logic       slotEnd;
   logic [2:0] slotLows;
   logic       slotHit;
   logic [3:0] slotKey;
   logic [2:0] pressSum;
   logic [1:0] pressCnt_d;
   logic [3:0] firstKey_d;

   // Two-flop synchronizer for the asynchronous, pulled-up row returns
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rowMeta_q <= 4'hF;
         rowSync_q <= 4'hF;
      end else begin
         rowMeta_q <= row_i;
         rowSync_q <= rowMeta_q;
      end
   end

   // Slot timer; the column strobe advances only when a slot expires
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slotCnt_q <= '0;
         col_q     <= COL_RESET;
         colIdx_q  <= 2'd0;
      end else if (slotEnd) begin
         slotCnt_q <= '0;
         col_q     <= {col_q[2:0], col_q[3]};
         colIdx_q  <= colIdx_q + 2'd1;
      end else begin
         slotCnt_q <= slotCnt_q + SLOT_W'(1);
      end
   end

   // Fold this slot's rows into the frame: saturating press count and the
   // first key seen (columns ascending, rows ascending within a column)
   always_comb begin
      slotEnd  = (slotCnt_q == SLOT_LAST);
      slotLows = 3'd0;
      slotHit  = 1'b0;
      slotKey  = 4'h0;
      for (int r = 3; r >= 0; r--) begin
         if (!rowSync_q[r]) begin
            slotLows = slotLows + 3'd1;
            slotHit  = 1'b1;
            slotKey  = keyLookup(2'(r), colIdx_q);
         end
      end
      pressSum   = {1'b0, pressCnt_q} + slotLows;
      pressCnt_d = pressCnt_q;
      firstKey_d = firstKey_q;
      if (slotEnd) begin
         pressCnt_d = (pressSum >= 3'd2) ? 2'd2 : pressSum[1:0];
         if ((pressCnt_q == 2'd0) && slotHit) begin
            firstKey_d = slotKey;
         end
      end
      frameDone_o = slotEnd && (colIdx_q == 2'd3);
      frameKey_o  = firstKey_d;
      case (pressCnt_d)
         2'd0:    frameClass_o = NONE;
         2'd1:    frameClass_o = SINGLE;
         default: frameClass_o = MULTI;
      endcase
   end

   // Frame accumulators restart empty once the last column has been sampled
   always_ff @(posedge clk) begin
      if (!rst_n || frameDone_o) begin
         pressCnt_q <= 2'd0;
         firstKey_q <= 4'h0;
      end else begin
         pressCnt_q <= pressCnt_d;
         firstKey_q <= firstKey_d;
      end
   end

   assign col_o = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives the column strobes, debounces whole
// scan frames and reports the accepted key as a hex code with a one-cycle
// press pulse and a held level.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W:0] DEB_TARGET = (CNT_W + 1)'(DEBOUNCE_SCANS);
   localparam bit ONE_SHOT = (DEBOUNCE_SCANS == 1);

   logic         frameDone;
   frame_class_e frameClass;
   logic [3:0]   frameKey;

   state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W:0]   cntInc;
   logic         cntReached;
   logic [3:0]   cand_q;
   logic [3:0]   keyCode_q;
   logic         keyValid_q;
   logic         keyHeld_q;

   keypad_col_scan #(
      .SCAN_DIV(SCAN_DIV)
   ) colScan (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_i       (ROW),
      .col_o       (COL),
      .frameDone_o (frameDone),
      .frameClass_o(frameClass),
      .frameKey_o  (frameKey)
   );

   assign cntInc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign cntReached = (cntInc >= DEB_TARGET);

   // Debounce FSM, stepped once per completed frame; key_valid is a one-cycle
   // pulse, so it is cleared on every cycle that does not accept a press
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cand_q     <= 4'h0;
         keyCode_q  <= 4'h0;
         keyValid_q <= 1'b0;
         keyHeld_q  <= 1'b0;
      end else begin
         keyValid_q <= 1'b0;
         if (frameDone) begin
            case (state_q)
               IDLE: begin
                  if (frameClass == SINGLE) begin
                     cand_q <= frameKey;
                     if (ONE_SHOT) begin
                        state_q    <= PRESSED;
                        cnt_q      <= '0;
                        keyCode_q  <= frameKey;
                        keyValid_q <= 1'b1;
                        keyHeld_q  <= 1'b1;
                     end else begin
                        state_q <= DEBOUNCE;
                        cnt_q   <= CNT_W'(1);
                     end
                  end
               end
               DEBOUNCE: begin
                  if (frameClass != SINGLE) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else if (frameKey != cand_q) begin
                     cand_q <= frameKey;
                     cnt_q  <= CNT_W'(1);
                  end else if (cntReached) begin
                     state_q    <= PRESSED;
                     cnt_q      <= '0;
                     keyCode_q  <= cand_q;
                     keyValid_q <= 1'b1;
                     keyHeld_q  <= 1'b1;
                  end else begin
                     cnt_q <= cntInc[CNT_W-1:0];
                  end
               end
               PRESSED: begin
                  if (frameClass == NONE) begin
                     if (ONE_SHOT) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        keyHeld_q <= 1'b0;
                     end else begin
                        state_q <= RELEASE;
                        cnt_q   <= CNT_W'(1);
                     end
                  end
               end
               RELEASE: begin
                  if (frameClass != NONE) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                  end else if (cntReached) begin
                     state_q   <= IDLE;
                     cnt_q     <= '0;
                     keyHeld_q <= 1'b0;
                  end else begin
                     cnt_q <= cntInc[CNT_W-1:0];
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign key_code  = keyCode_q;
   assign key_valid = keyValid_q;
   assign key_held  = keyHeld_q;

endmodule
